// File: rtl/hook_motion_ctrl.sv
// -----------------------------------------------------------------------------
// hook_motion_ctrl
//
// Motion/state controller for the fishing-game hook renderer. It tracks the
// hook position in 1/10-pixel fixed point, the line-cut flag and the row of
// the cut, and the coarse game state read by the pixel colour stage.
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous reset, active low
//   tick        in   1-cycle movement strobe, once per frame
//   btn_left    in   level, aim left
//   btn_right   in   level, aim right
//   btn_up      in   level, aim up
//   btn_down    in   level, aim down
//   btn_cast    in   1-cycle pulse, cast the line
//   btn_reel    in   level, reel in while fishing
//   fish_hit    in   1-cycle pulse, a fish touches the hook
//   line_snap   in   1-cycle pulse, the line breaks
//   h_position  out  hook x, 1/10 px
//   v_position  out  hook y, 1/10 px
//   cut         out  line is cut
//   cut_v       out  pixel row at which the line was cut
//   state       out  0 AIM, 1 FISHING, 2 CATCH, 3 HOLD
//   caught      out  1-cycle pulse on a successful landing
// -----------------------------------------------------------------------------
module hook_motion_ctrl #(
    parameter logic [13:0] H_MIN      = 14'd0,
    parameter logic [13:0] H_MAX      = 14'd6300,
    parameter logic [13:0] V_TOP      = 14'd620,
    parameter logic [13:0] V_MAX      = 14'd4700,
    parameter logic [13:0] LINE_X     = 14'd2790,
    parameter logic [13:0] MOVE_STEP  = 14'd20,
    parameter logic [13:0] SINK_STEP  = 14'd15,
    parameter logic [13:0] REEL_STEP  = 14'd25,
    parameter logic [5:0]  HOLD_TICKS = 6'd60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_cast,
    input  logic        btn_reel,
    input  logic        fish_hit,
    input  logic        line_snap,
    output logic [13:0] h_position,
    output logic [13:0] v_position,
    output logic        cut,
    output logic [9:0]  cut_v,
    output logic [1:0]  state,
    output logic        caught
);

    typedef enum logic [2:0] {
        S_AIM,
        S_LINE,
        S_SNAP,
        S_CATCH,
        S_HOLD
    } fsm_t;

    localparam logic [9:0] CUT_V_INIT = 10'(V_TOP / 14'd10);

    fsm_t        fsm_q,      fsm_d;
    logic [13:0] h_q,        h_d;
    logic [13:0] v_q,        v_d;
    logic        cut_q,      cut_d;
    logic [9:0]  cut_v_q,    cut_v_d;
    logic [1:0]  state_q,    state_d;
    logic        caught_q,   caught_d;
    logic [5:0]  hold_cnt_q, hold_cnt_d;

    // Saturating step down: the threshold is formed in 15 bits so lo + step
    // cannot wrap, and the subtraction only happens when it cannot underflow.
    function automatic logic [13:0] dec_clamp(input logic [13:0] val,
                                              input logic [13:0] step,
                                              input logic [13:0] lo);
        logic [14:0] floor15;
        floor15 = {1'b0, lo} + {1'b0, step};
        if ({1'b0, val} < floor15) return lo;
        return val - step;
    endfunction

    // Saturating step up, summed in 15 bits so the compare sees no wrap.
    function automatic logic [13:0] inc_clamp(input logic [13:0] val,
                                              input logic [13:0] step,
                                              input logic [13:0] hi);
        logic [14:0] sum15;
        sum15 = {1'b0, val} + {1'b0, step};
        if (sum15 > {1'b0, hi}) return hi;
        return 14'(sum15);
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through the case below can leave one unassigned and infer a latch.
        fsm_d      = fsm_q;
        h_d        = h_q;
        v_d        = v_q;
        cut_d      = cut_q;
        cut_v_d    = cut_v_q;
        caught_d   = 1'b0;
        hold_cnt_d = hold_cnt_q;

        unique case (fsm_q)
            S_AIM: begin
                // Casting reloads the anchor position and overrides any
                // movement requested on the same cycle.
                if (btn_cast) begin
                    fsm_d = S_LINE;
                    h_d   = LINE_X;
                    v_d   = V_TOP;
                end else if (tick) begin
                    if (btn_left && !btn_right)
                        h_d = dec_clamp(h_q, MOVE_STEP, H_MIN);
                    else if (btn_right && !btn_left)
                        h_d = inc_clamp(h_q, MOVE_STEP, H_MAX);
                    if (btn_up && !btn_down)
                        v_d = dec_clamp(v_q, MOVE_STEP, V_TOP);
                    else if (btn_down && !btn_up)
                        v_d = inc_clamp(v_q, MOVE_STEP, V_MAX);
                end
            end

            S_LINE: begin
                if (line_snap) begin
                    fsm_d   = S_SNAP;
                    cut_d   = 1'b1;
                    cut_v_d = 10'(v_q / 14'd10);
                end else if (fish_hit) begin
                    fsm_d = S_CATCH;
                end else if (tick) begin
                    if (btn_reel) begin
                        v_d = dec_clamp(v_q, REEL_STEP, V_TOP);
                        if (v_d == V_TOP) fsm_d = S_AIM;
                    end else begin
                        v_d = inc_clamp(v_q, SINK_STEP, V_MAX);
                    end
                end
            end

            S_SNAP: begin
                // The broken line sinks to the bottom; leaving happens on the
                // first edge that sees it resting there, tick or not.
                if (v_q == V_MAX) begin
                    fsm_d      = S_HOLD;
                    hold_cnt_d = 6'd0;
                end else if (tick) begin
                    v_d = inc_clamp(v_q, SINK_STEP, V_MAX);
                end
            end

            S_CATCH: begin
                if (tick) begin
                    v_d = dec_clamp(v_q, REEL_STEP, V_TOP);
                    if (v_d == V_TOP) begin
                        fsm_d      = S_HOLD;
                        caught_d   = 1'b1;
                        hold_cnt_d = 6'd0;
                    end
                end
            end

            S_HOLD: begin
                if (tick) begin
                    if (hold_cnt_q == HOLD_TICKS - 6'd1) begin
                        fsm_d      = S_AIM;
                        cut_d      = 1'b0;
                        cut_v_d    = CUT_V_INIT;
                        hold_cnt_d = 6'd0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 6'd1;
                    end
                end
            end

            default: fsm_d = S_AIM;
        endcase

        // The external state is registered from the next internal state so it
        // changes on the same edge as the FSM; LINE and SNAP both read as
        // fishing.
        unique case (fsm_d)
            S_AIM:   state_d = 2'd0;
            S_LINE:  state_d = 2'd1;
            S_SNAP:  state_d = 2'd1;
            S_CATCH: state_d = 2'd2;
            S_HOLD:  state_d = 2'd3;
            default: state_d = 2'd0;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only, and all state uses
    // non-blocking assignment so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q      <= S_AIM;
            h_q        <= LINE_X;
            v_q        <= V_TOP;
            cut_q      <= 1'b0;
            cut_v_q    <= CUT_V_INIT;
            state_q    <= 2'd0;
            caught_q   <= 1'b0;
            hold_cnt_q <= 6'd0;
        end else begin
            fsm_q      <= fsm_d;
            h_q        <= h_d;
            v_q        <= v_d;
            cut_q      <= cut_d;
            cut_v_q    <= cut_v_d;
            state_q    <= state_d;
            caught_q   <= caught_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign h_position = h_q;
    assign v_position = v_q;
    assign cut        = cut_q;
    assign cut_v      = cut_v_q;
    assign state      = state_q;
    assign caught     = caught_q;

endmodule
